// File: rtl/clk_en_pll_gen.sv
// clk_en_pll_gen
//   Runtime-reconfigurable clock-enable generator. Each of NUM_CH channels
//   divides clkin by a programmable ratio with a coarse phase offset and
//   produces a one-cycle enable pulse plus a divided square wave, both as
//   registered signals in the clkin domain. Every accepted reconfiguration
//   re-aligns all channels and drops lock until LOCK_CYCLES settle cycles pass.
//
//   Optional build macro: CLK_EN_PLL_GEN_GATE_EN
//     defined   - clk_en/clk_out held at 0 while lock is low
//     undefined - channels free-run during SETTLE; only ALIGN stops counting
//
// Ports
//   clkin      in   single clock
//   reset      in   synchronous, active-high reset
//   cfg_we     in   config write strobe (taken only while cfg_ready=1)
//   cfg_ch     in   channel index for the write
//   cfg_div    in   divide ratio, 0 disables the channel
//   cfg_phase  in   phase offset in clkin cycles (>= cfg_div is clamped to 0)
//   cfg_ready  out  block accepts a config write
//   cfg_err    out  one-cycle pulse on rejected or clamped write
//   lock       out  all channels aligned and settled
//   clk_en     out  per-channel one-cycle enable, once per divided period
//   clk_out    out  per-channel divided square wave (high-biased for odd div)
module clk_en_pll_gen #(
    parameter int NUM_CH      = 6,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              lock,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_out
);

    localparam int SET_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [DIV_W-1:0]   div_q   [NUM_CH];
    logic [DIV_W-1:0]   div_d   [NUM_CH];
    logic [DIV_W-1:0]   phase_q [NUM_CH];
    logic [DIV_W-1:0]   phase_d [NUM_CH];
    logic [DIV_W-1:0]   cnt_q   [NUM_CH];
    logic [DIV_W-1:0]   cnt_d   [NUM_CH];
    logic               lock_q, lock_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic [NUM_CH-1:0]  en_q, en_d;
    logic [NUM_CH-1:0]  out_q, out_d;

    logic               wr_ok, wr_bad_ch, wr_acc, wr_clamp;
    logic [DIV_W:0]     half;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        lock_d   = lock_q;
        div_d    = div_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        en_d     = '0;
        out_d    = '0;
        half     = '0;

        // ready_q tracks state_q != ALIGN, so it doubles as the write gate
        wr_ok     = cfg_we && ready_q;
        wr_bad_ch = (int'(cfg_ch) >= NUM_CH);
        wr_acc    = wr_ok && !wr_bad_ch;
        wr_clamp  = (cfg_div != '0) && (cfg_phase >= cfg_div);
        err_d     = wr_ok && (wr_bad_ch || wr_clamp);

        case (state_q)
            ALIGN: begin
                state_d  = SETTLE;
                settle_d = '0;
                lock_d   = 1'b0;
            end
            SETTLE: begin
                if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
                    state_d = LOCKED;
                    lock_d  = 1'b1;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            LOCKED: lock_d = 1'b1;
            default: begin
                state_d = ALIGN;
                lock_d  = 1'b0;
            end
        endcase

        // Counters advance with the configuration in force before this edge;
        // a new ratio only takes effect through the following ALIGN reload.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (div_q[i] == '0) begin
                cnt_d[i] = '0;
            end else if (state_q == ALIGN) begin
                cnt_d[i] = phase_q[i];
            end else if (cnt_q[i] >= div_q[i] - 1'b1) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            half     = ({1'b0, div_q[i]} + 1'b1) >> 1;
            en_d[i]  = (div_q[i] != '0) && (cnt_d[i] == '0);
            out_d[i] = (div_q[i] != '0) && ({1'b0, cnt_d[i]} < half);

            if (wr_acc && (cfg_ch == CH_W'(i))) begin
                div_d[i]   = cfg_div;
                phase_d[i] = wr_clamp ? '0 : cfg_phase;
            end
        end

        if (wr_acc) begin
            state_d = ALIGN;
            lock_d  = 1'b0;
        end

`ifdef CLK_EN_PLL_GEN_GATE_EN
        if (!lock_d) begin
            en_d  = '0;
            out_d = '0;
        end
`endif

        ready_d = (state_d != ALIGN);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q  <= ALIGN;
            settle_q <= '0;
            lock_q   <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= '0;
            out_q    <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                div_q[i]   <= DIV_W'(DEFAULT_DIV);
                phase_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            lock_q   <= lock_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            en_q     <= en_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign lock      = lock_q;
    assign clk_en    = en_q;
    assign clk_out   = out_q;

endmodule

// File: tb/tb_clk_en_pll_gen.sv
// Testbench for clk_en_pll_gen: directed reconfiguration scenarios followed
// by random config traffic, all checked cycle by cycle against an arithmetic
// model (counter value = (phase + cycles since align) mod div).
module tb_clk_en_pll_gen;

    localparam int NUM_CH      = 6;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;
    localparam int LOCK_CYCLES = 16;
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              clkin = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_ready;
    logic              cfg_err;
    logic              lock;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] clk_out;

    clk_en_pll_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .lock      (lock),
        .clk_en    (clk_en),
        .clk_out   (clk_out)
    );

    always #5 clkin = ~clkin;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_div [NUM_CH];
    int m_ph  [NUM_CH];
    int k;                       // edges since the last reset release / accepted write
    logic [NUM_CH-1:0] e_en, e_out;
    logic e_lock, e_ready, e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predict the effect of the coming edge, apply it, then compare.
    task automatic step();
        bit acc, err, lk;
        int knew, c;
        if (reset) begin
            k = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = DEFAULT_DIV;
                m_ph[i]  = 0;
            end
            e_en = '0; e_out = '0; e_lock = 0; e_ready = 0; e_err = 0;
        end else begin
            acc = 0;
            err = 0;
            if (cfg_we && (k >= 1)) begin
                if (int'(cfg_ch) >= NUM_CH) err = 1;
                else begin
                    acc = 1;
                    if (cfg_div != 0 && cfg_phase >= cfg_div) err = 1;
                end
            end
            knew = acc ? 0 : k + 1;
            lk   = (knew >= LOCK_CYCLES + 1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_div[i] == 0) begin
                    e_en[i]  = 0;
                    e_out[i] = 0;
                end else begin
                    c        = (m_ph[i] + k) % m_div[i];
                    e_en[i]  = (c == 0);
                    e_out[i] = (c < (m_div[i] + 1) / 2);
                end
            end
`ifdef CLK_EN_PLL_GEN_GATE_EN
            if (!lk) begin
                e_en  = '0;
                e_out = '0;
            end
`endif
            if (acc) begin
                m_div[cfg_ch] = int'(cfg_div);
                m_ph[cfg_ch]  = err ? 0 : int'(cfg_phase);
            end
            k       = knew;
            e_lock  = lk;
            e_ready = (knew >= 1);
            e_err   = err;
        end
        @(posedge clkin);
        #1;
        check("clk_en",    clk_en,    e_en);
        check("clk_out",   clk_out,   e_out);
        check("lock",      lock,      e_lock);
        check("cfg_ready", cfg_ready, e_ready);
        check("cfg_err",   cfg_err,   e_err);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input int ch, input int dv, input int ph);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        step();
        cfg_we = 1'b0;
    endtask

    // Bounded count of edges until lock reads 1.
    task automatic lock_latency(input string tag, input int exp);
        int n;
        n = 0;
        while (!lock && n < 40) begin
            step();
            n++;
        end
        check(tag, n, exp);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
        k = 0;
        for (int i = 0; i < NUM_CH; i++) begin m_div[i] = DEFAULT_DIV; m_ph[i] = 0; end
        run(3);
        check("rst_lock", lock, 0);

        reset = 1'b0;
        lock_latency("lock_after_reset", LOCK_CYCLES + 1);
        run(8);

        // ch0 div5 ph0, then ch1 div5 ph2 once ready returns
        write(0, 5, 0);
        check("lock_drop", lock, 0);
        step();
        write(1, 5, 2);
        lock_latency("lock_after_ch1", LOCK_CYCLES + 1);
        run(15);

        // disable ch2
        write(2, 0, 3);
        lock_latency("lock_after_ch2", LOCK_CYCLES + 1);
        run(12);

        // clamped phase
        write(3, 4, 7);
        check("clamp_err", cfg_err, 1);
        step();
        check("clamp_err_pulse", cfg_err, 0);
        lock_latency("lock_after_clamp", LOCK_CYCLES);
        run(12);

        // invalid channel while locked, then write during ALIGN
        write(6, 3, 1);
        check("badch_lock", lock, 1);
        run(5);
        write(5, 3, 1);
        cfg_we = 1'b1; cfg_ch = CH_W'(4); cfg_div = 8'd7; cfg_phase = 8'd9;
        step();
        check("align_we_noerr", cfg_err, 0);
        cfg_we = 1'b0;
        lock_latency("lock_after_ch5", LOCK_CYCLES);
        run(10);

        // reset mid-SETTLE after a div=9 write
        write(4, 9, 0);
        run(5);
        reset = 1'b1;
        run(2);
        check("rst_mid_outputs", clk_en | clk_out, 0);
        reset = 1'b0;
        lock_latency("lock_after_rst2", LOCK_CYCLES + 1);
        run(10);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            reset  = ($urandom_range(0, 299) == 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_ch = CH_W'($urandom_range(0, (1 << CH_W) - 1));
            if ($urandom_range(0, 9) == 0) cfg_div = DIV_W'($urandom_range(200, 255));
            else cfg_div = DIV_W'($urandom_range(0, 12));
            cfg_phase = DIV_W'($urandom_range(0, 15));
            step();
        end
        reset = 1'b0; cfg_we = 1'b0;
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
